// File: rtl/priority_iter_encoder.sv
// Sequential multi-cluster priority encoder: snapshots valid flags and counts on load,
// then reports up to MXCLUSTERS winners, lowest index first, one per clock.
module priority_iter_encoder #(
    parameter int MXKEYS     = 192,
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8,
    parameter int MXPASSB    = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               load,
    input  logic [MXPASSB-1:0]                 pass_in,
    input  logic [MXKEYS-1:0]                  vpfs_in,
    input  logic [MXKEYS*MXCNTB-1:0]           cnts_in,
    output logic                               vpf,
    output logic [MXKEYBITS-1:0]               adr,
    output logic [MXCNTB-1:0]                  cnt,
    output logic [MXPASSB-1:0]                 pass_out,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(MXCLUSTERS+1)-1:0]    nfound,
    output logic                               overflow,
    output logic                               drop
);

    localparam int NFB = $clog2(MXCLUSTERS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                     state_q;
    logic [MXKEYS-1:0]          mask_q;
    logic [MXKEYS-1:0]          mask_d;
    logic [MXKEYS*MXCNTB-1:0]   cnts_q;
    logic [MXPASSB-1:0]         pass_q;
    logic [NFB-1:0]             found_q;
    logic                       vpf_q;
    logic [MXKEYBITS-1:0]       adr_q;
    logic [MXCNTB-1:0]          cnt_q;
    logic                       done_q;
    logic [NFB-1:0]             nfound_q;
    logic                       overflow_q;
    logic                       drop_q;

    logic                       winFound;
    logic [MXKEYBITS-1:0]       winIdx;
    logic [MXCNTB-1:0]          winCnt;

    // Walking down from the top leaves the lowest set index as the final assignment.
    always_comb begin
        winIdx = '0;
        winCnt = '0;
        for (int i = MXKEYS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                winIdx = MXKEYBITS'(i);
                winCnt = cnts_q[i*MXCNTB +: MXCNTB];
            end
        end
    end

    assign winFound = |mask_q;
    assign mask_d   = mask_q & (mask_q - MXKEYS'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cnts_q     <= '0;
            pass_q     <= '0;
            found_q    <= '0;
            vpf_q      <= 1'b0;
            adr_q      <= '1;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            nfound_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            vpf_q      <= 1'b0;
            adr_q      <= '1;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            nfound_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (load) begin
                        state_q <= SCAN;
                        mask_q  <= vpfs_in;
                        cnts_q  <= cnts_in;
                        pass_q  <= pass_in;
                        found_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    drop_q <= load;
                    // After the capping winner the mask already excludes it, so any bit left is an overflow.
                    if (!winFound || found_q == NFB'(MXCLUSTERS)) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        nfound_q   <= found_q;
                        overflow_q <= winFound;
                    end else begin
                        vpf_q   <= 1'b1;
                        adr_q   <= winIdx;
                        cnt_q   <= winCnt;
                        mask_q  <= mask_d;
                        found_q <= found_q + NFB'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vpf      = vpf_q;
    assign adr      = adr_q;
    assign cnt      = cnt_q;
    assign pass_out = pass_q;
    assign busy     = (state_q == SCAN);
    assign done     = done_q;
    assign nfound   = nfound_q;
    assign overflow = overflow_q;
    assign drop     = drop_q;

endmodule
